// File: rtl/home_inventory_pkg.sv
// Shared constants for the home-inventory Wishbone load-cell controller:
// register offsets, ID/VERSION values, SCALE reset value and IRQ_STAT bit indices.
package home_inventory_pkg;

   localparam logic [31:0] ID_VALUE      = 32'h4849_4348;
   localparam logic [31:0] VERSION_VALUE = 32'h0000_0002;
   localparam logic [31:0] SCALE_RESET   = 32'h0001_0000;

   localparam logic [11:0] ADDR_ID        = 12'h000;
   localparam logic [11:0] ADDR_VERSION   = 12'h004;
   localparam logic [11:0] ADDR_CTRL      = 12'h100;
   localparam logic [11:0] ADDR_IRQ_EN    = 12'h104;
   localparam logic [11:0] ADDR_STATUS    = 12'h108;
   localparam logic [11:0] ADDR_IRQ_STAT  = 12'h10C;
   localparam logic [11:0] ADDR_ADC_CFG   = 12'h200;
   localparam logic [11:0] ADDR_ADC_CMD   = 12'h204;
   localparam logic [11:0] ADDR_ADC_RAW   = 12'h210;
   localparam logic [11:0] ADDR_TARE      = 12'h300;
   localparam logic [11:0] ADDR_SCALE     = 12'h320;
   localparam logic [11:0] ADDR_EVT_COUNT = 12'h400;
   localparam logic [11:0] ADDR_EVT_CLR   = 12'h440;

   localparam int IRQ_EVT_BIT = 0;
   localparam int IRQ_OVF_BIT = 1;
   localparam int IRQ_ADC_BIT = 2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ACK
   } wbState_t;

   // Byte-lane merge: lanes with a 0 strobe keep their old contents.
   function automatic logic [31:0] applySel(input logic [31:0] oldVal,
                                            input logic [31:0] newVal,
                                            input logic [3:0]  sel);
      logic [31:0] result;
      for (int b = 0; b < 4; b++) begin
         result[8*b +: 8] = sel[b] ? newVal[8*b +: 8] : oldVal[8*b +: 8];
      end
      return result;
   endfunction

   function automatic logic [11:0] chAddr(input logic [11:0] base, input int ch);
      return base + 12'(ch * 4);
   endfunction

endpackage

// File: rtl/hi_evt_counter.sv
// Per-channel saturating event counter with synchronous clear (clear beats an
// incoming event) and an overflow strobe for events that arrive while saturated.
module hi_evt_counter #(
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   input  logic             i_pulse,
   input  logic             i_clr,
   output logic [CNT_W-1:0] o_count,
   output logic             o_evt,
   output logic             o_ovf
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] r_count;
   logic             w_evt;

   assign w_evt   = i_en & i_pulse & ~i_clr;
   assign o_evt   = w_evt;
   assign o_ovf   = w_evt & (r_count == CNT_MAX);
   assign o_count = r_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (w_evt && (r_count != CNT_MAX)) begin
         r_count <= r_count + 1'b1;
      end
   end

endmodule

// File: rtl/home_inventory_wb_mc.sv
// Wishbone register block for a multi-channel load-cell inventory scale.
// Optional HOME_INV_WB_SNAPSHOT_EN: reading EVT_COUNT_CH0 freezes all counters into shadows.
module home_inventory_wb_mc
   import home_inventory_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int CNT_W       = 16,
   parameter int WAIT_STATES = 0
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_ni,
   input  logic                wbs_stb_i,
   input  logic                wbs_cyc_i,
   input  logic                wbs_we_i,
   input  logic [3:0]          wbs_sel_i,
   input  logic [31:0]         wbs_dat_i,
   input  logic [31:0]         wbs_adr_i,
   output logic                wbs_ack_o,
   output logic [31:0]         wbs_dat_o,
   input  logic [7:0]          core_status,
   input  logic [NUM_CH-1:0]   evt_pulse_i,
   input  logic [32*NUM_CH-1:0] adc_raw_i,
   input  logic                adc_done_i,
   output logic                ctrl_enable,
   output logic                ctrl_start,
   output logic                adc_start,
   output logic [2:0]          irq_en,
   output logic                irq_o
);

   localparam logic [1:0] WS_LAST = (WAIT_STATES == 0) ? 2'd0 : 2'(WAIT_STATES - 1);

   wbState_t    r_state, w_stateNext;
   logic [1:0]  r_waitCnt, w_waitCntNext;
   logic        w_req, w_inMap, w_wrEn;
   logic [11:0] w_off;
   logic [31:0] w_rdData;

   logic        r_ctrlEnable, r_ctrlStart, r_adcStart, r_irq;
   logic [2:0]  r_irqEn, r_irqStat, w_irqSet, w_irqClr;
   logic [3:0]  r_adcCfg;
   logic [31:0] r_tare  [NUM_CH];
   logic [31:0] r_scale [NUM_CH];

   logic [NUM_CH-1:0] w_evtClr, w_evt, w_ovf;
   logic [CNT_W-1:0]  w_count [NUM_CH];

   assign w_req   = wbs_stb_i & wbs_cyc_i;
   // Only word-aligned offsets inside the 4 KiB window decode; anything else reads 0.
   assign w_inMap = (wbs_adr_i[31:12] == 20'd0) && (wbs_adr_i[1:0] == 2'b00);
   assign w_off   = wbs_adr_i[11:0];
   assign wbs_ack_o = (r_state == ST_ACK);
   assign w_wrEn    = wbs_ack_o & wbs_we_i & w_inMap;

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_state   <= ST_IDLE;
         r_waitCnt <= '0;
      end else begin
         r_state   <= w_stateNext;
         r_waitCnt <= w_waitCntNext;
      end
   end

   always_comb begin
      w_stateNext   = r_state;
      w_waitCntNext = r_waitCnt;
      case (r_state)
         ST_IDLE: begin
            if (w_req) begin
               w_waitCntNext = '0;
               w_stateNext   = (WAIT_STATES == 0) ? ST_ACK : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (!w_req) begin
               w_stateNext = ST_IDLE;
            end else if (r_waitCnt == WS_LAST) begin
               w_stateNext = ST_ACK;
            end else begin
               w_waitCntNext = r_waitCnt + 2'd1;
            end
         end
         ST_ACK:  w_stateNext = ST_IDLE;
         default: w_stateNext = ST_IDLE;
      endcase
   end

   always_comb begin
      w_irqSet = '0;
      w_irqSet[IRQ_EVT_BIT] = |w_evt;
      w_irqSet[IRQ_OVF_BIT] = |w_ovf;
      w_irqSet[IRQ_ADC_BIT] = adc_done_i;
      w_irqClr = (w_wrEn && (w_off == ADDR_IRQ_STAT) && wbs_sel_i[0]) ? wbs_dat_i[2:0] : 3'd0;
      w_evtClr = (w_wrEn && (w_off == ADDR_EVT_CLR) && wbs_sel_i[0]) ? wbs_dat_i[NUM_CH-1:0] : '0;
   end

   // Control/status registers; start strobes are registered so they land the cycle after ACK.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_ctrlEnable <= 1'b0;
         r_ctrlStart  <= 1'b0;
         r_adcStart   <= 1'b0;
         r_irqEn      <= '0;
         r_irqStat    <= '0;
         r_adcCfg     <= '0;
         r_irq        <= 1'b0;
      end else begin
         r_ctrlStart <= w_wrEn && (w_off == ADDR_CTRL) && wbs_sel_i[0] && wbs_dat_i[1];
         r_adcStart  <= w_wrEn && (w_off == ADDR_ADC_CMD) && wbs_sel_i[0] && wbs_dat_i[0];
         if (w_wrEn && (w_off == ADDR_CTRL) && wbs_sel_i[0]) begin
            r_ctrlEnable <= wbs_dat_i[0];
         end
         if (w_wrEn && (w_off == ADDR_IRQ_EN) && wbs_sel_i[0]) begin
            r_irqEn <= wbs_dat_i[2:0];
         end
         if (w_wrEn && (w_off == ADDR_ADC_CFG) && wbs_sel_i[0]) begin
            r_adcCfg <= wbs_dat_i[3:0];
         end
         r_irqStat <= (r_irqStat & ~w_irqClr) | w_irqSet;
         r_irq     <= |(r_irqStat & r_irqEn);
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         for (int c = 0; c < NUM_CH; c++) begin
            r_tare[c]  <= '0;
            r_scale[c] <= SCALE_RESET;
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (w_wrEn && (w_off == chAddr(ADDR_TARE, c))) begin
               r_tare[c] <= applySel(r_tare[c], wbs_dat_i, wbs_sel_i);
            end
            if (w_wrEn && (w_off == chAddr(ADDR_SCALE, c))) begin
               r_scale[c] <= applySel(r_scale[c], wbs_dat_i, wbs_sel_i);
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
      hi_evt_counter #(.CNT_W(CNT_W)) u_cnt (
         .i_clk   (wb_clk_i),
         .i_rst_n (wb_rst_ni),
         .i_en    (r_ctrlEnable),
         .i_pulse (evt_pulse_i[g]),
         .i_clr   (w_evtClr[g]),
         .o_count (w_count[g]),
         .o_evt   (w_evt[g]),
         .o_ovf   (w_ovf[g])
      );
   end

`ifdef HOME_INV_WB_SNAPSHOT_EN
   logic [CNT_W-1:0] r_shadow [NUM_CH];
   logic             w_snapTake;

   assign w_snapTake = wbs_ack_o & ~wbs_we_i & w_inMap & (w_off == ADDR_EVT_COUNT);

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         for (int c = 0; c < NUM_CH; c++) r_shadow[c] <= '0;
      end else if (w_snapTake) begin
         for (int c = 0; c < NUM_CH; c++) r_shadow[c] <= w_count[c];
      end
   end
`endif

   always_comb begin
      w_rdData = '0;
      case (w_off)
         ADDR_ID:       w_rdData = ID_VALUE;
         ADDR_VERSION:  w_rdData = VERSION_VALUE;
         ADDR_CTRL:     w_rdData = {31'd0, r_ctrlEnable};
         ADDR_IRQ_EN:   w_rdData = {29'd0, r_irqEn};
         ADDR_STATUS:   w_rdData = {24'd0, core_status};
         ADDR_IRQ_STAT: w_rdData = {29'd0, r_irqStat};
         ADDR_ADC_CFG:  w_rdData = {28'd0, r_adcCfg};
         default:       w_rdData = '0;
      endcase
      for (int c = 0; c < NUM_CH; c++) begin
         if (w_off == chAddr(ADDR_ADC_RAW, c)) w_rdData = adc_raw_i[32*c +: 32];
         if (w_off == chAddr(ADDR_TARE, c))    w_rdData = r_tare[c];
         if (w_off == chAddr(ADDR_SCALE, c))   w_rdData = r_scale[c];
         if (w_off == chAddr(ADDR_EVT_COUNT, c)) begin
`ifdef HOME_INV_WB_SNAPSHOT_EN
            w_rdData = (c == 0) ? 32'(w_count[c]) : 32'(r_shadow[c]);
`else
            w_rdData = 32'(w_count[c]);
`endif
         end
      end
      if (!w_inMap) w_rdData = '0;
   end

   assign wbs_dat_o   = (wbs_ack_o && !wbs_we_i) ? w_rdData : 32'd0;
   assign ctrl_enable = r_ctrlEnable;
   assign ctrl_start  = r_ctrlStart;
   assign adc_start   = r_adcStart;
   assign irq_en      = r_irqEn;
   assign irq_o       = r_irq;

endmodule

// File: tb/tb_home_inventory_wb_mc.sv
// Directed self-checking bench for home_inventory_wb_mc (NUM_CH=4, CNT_W=8, WAIT_STATES=2).
module tb_home_inventory_wb_mc;

   localparam int NUM_CH      = 4;
   localparam int CNT_W       = 8;
   localparam int WAIT_STATES = 2;

   logic                clk = 1'b0;
   logic                rstN = 1'b0;
   logic                stb, cyc, we;
   logic [3:0]          sel;
   logic [31:0]         datI, adr, datO;
   logic                ack;
   logic [7:0]          coreStatus;
   logic [NUM_CH-1:0]   evtPulse;
   logic [32*NUM_CH-1:0] adcRaw;
   logic                adcDone;
   logic                ctrlEnable, ctrlStart, adcStart, irqO;
   logic [2:0]          irqEn;

   int assertions = 0;
   int failures   = 0;

   always #5 clk = ~clk;

   home_inventory_wb_mc #(
      .NUM_CH(NUM_CH), .CNT_W(CNT_W), .WAIT_STATES(WAIT_STATES)
   ) dut (
      .wb_clk_i(clk), .wb_rst_ni(rstN),
      .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
      .wbs_dat_i(datI), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(datO),
      .core_status(coreStatus), .evt_pulse_i(evtPulse), .adc_raw_i(adcRaw),
      .adc_done_i(adcDone), .ctrl_enable(ctrlEnable), .ctrl_start(ctrlStart),
      .adc_start(adcStart), .irq_en(irqEn), .irq_o(irqO)
   );

   // One bus cycle; ackPulse drives evt_pulse_i during the ACK cycle to create collisions.
   task automatic applyStimulus(input logic isWrite, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] s, input logic [NUM_CH-1:0] ackPulse,
                                output logic [31:0] rd, output int lat);
      bit got = 0;
      @(negedge clk);
      stb = 1'b1; cyc = 1'b1; we = isWrite; adr = a; datI = d; sel = s;
      rd = '0; lat = 0;
      for (int i = 1; i <= 16 && !got; i++) begin
         @(posedge clk); #1;
         if (ack) begin got = 1; lat = i; rd = datO; end
      end
      if (!got) begin
         assertions++; failures++;
         $display("[TB] FAIL bus_timeout: adr %h got no ack, required ack within 16 cycles", a);
      end
      evtPulse = ackPulse;
      @(posedge clk); #1;
      stb = 1'b0; cyc = 1'b0; we = 1'b0; evtPulse = '0;
   endtask

   task automatic wbWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] rd;
      int lat;
      applyStimulus(1'b1, a, d, s, '0, rd, lat);
   endtask

   task automatic wbRead(input logic [31:0] a, output logic [31:0] rd);
      int lat;
      applyStimulus(1'b0, a, 32'd0, 4'hF, '0, rd, lat);
   endtask

   // Reading CH0 first keeps results identical with or without the snapshot build.
   task automatic readCount(input int ch, output logic [31:0] rd);
      if (ch != 0) wbRead(32'h400, rd);
      wbRead(32'h400 + 32'(ch * 4), rd);
   endtask

   task automatic pulseEvt(input int ch, input int n);
      repeat (n) begin
         @(negedge clk); evtPulse[ch] = 1'b1;
         @(negedge clk); evtPulse[ch] = 1'b0;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      assertions++; if (ack !== 1'b0) begin failures++; $display("[TB] FAIL reset_ack: got %b expected 0", ack); end
      assertions++; if (ctrlEnable !== 1'b0) begin failures++; $display("[TB] FAIL reset_enable: got %b expected 0", ctrlEnable); end
      assertions++; if (ctrlStart !== 1'b0) begin failures++; $display("[TB] FAIL reset_ctrl_start: got %b expected 0", ctrlStart); end
      assertions++; if (adcStart !== 1'b0) begin failures++; $display("[TB] FAIL reset_adc_start: got %b expected 0", adcStart); end
      assertions++; if (irqEn !== 3'b000) begin failures++; $display("[TB] FAIL reset_irq_en: got %b expected 000", irqEn); end
      assertions++; if (irqO !== 1'b0) begin failures++; $display("[TB] FAIL reset_irq_o: got %b expected 0", irqO); end
      @(negedge clk); rstN = 1'b1;
   endtask

   task automatic test_id_version();
      logic [31:0] rd;
      wbRead(32'h000, rd);
      assertions++; if (rd !== 32'h4849_4348) begin failures++; $display("[TB] FAIL id: got %h expected 48494348", rd); end
      wbRead(32'h004, rd);
      assertions++; if (rd !== 32'h0000_0002) begin failures++; $display("[TB] FAIL version: got %h expected 00000002", rd); end
      wbRead(32'h320, rd);
      assertions++; if (rd !== 32'h0001_0000) begin failures++; $display("[TB] FAIL scale0_reset: got %h expected 00010000", rd); end
      wbRead(32'h304, rd);
      assertions++; if (rd !== 32'h0) begin failures++; $display("[TB] FAIL tare1_reset: got %h expected 0", rd); end
      wbRead(32'h10C, rd);
      assertions++; if (rd !== 32'h0) begin failures++; $display("[TB] FAIL irq_stat_reset: got %h expected 0", rd); end
   endtask

   task automatic test_back_to_back();
      logic [7:0]  ackVec;
      logic [31:0] rd = '0;
      @(negedge clk);
      stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h000; sel = 4'hF;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         ackVec[i] = ack;
         if (i == 2) rd = datO;
      end
      stb = 1'b0; cyc = 1'b0;
      assertions++; if (ackVec !== 8'b0100_0100) begin failures++; $display("[TB] FAIL b2b_ack_pattern: got %b expected 01000100", ackVec); end
      assertions++; if (rd !== 32'h4849_4348) begin failures++; $display("[TB] FAIL b2b_data: got %h expected 48494348", rd); end
   endtask

   task automatic test_abort();
      int ackCount = 0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = 32'h104; datI = 32'h7; sel = 4'hF;
         @(posedge clk); #1;
         if (k == 0) stb = 1'b0; else cyc = 1'b0;
         repeat (5) begin @(posedge clk); #1; if (ack) ackCount++; end
         stb = 1'b0; cyc = 1'b0; we = 1'b0;
      end
      assertions++; if (ackCount !== 0) begin failures++; $display("[TB] FAIL abort_ack: got %0d acks expected 0", ackCount); end
      assertions++; if (irqEn !== 3'b000) begin failures++; $display("[TB] FAIL abort_side_effect: got %b expected 000", irqEn); end
   endtask

   task automatic test_ctrl();
      logic [31:0] rd;
      int lat;
      applyStimulus(1'b1, 32'h100, 32'h3, 4'hF, '0, rd, lat);
      assertions++; if (lat !== 3) begin failures++; $display("[TB] FAIL ctrl_ack_latency: got %0d expected 3", lat); end
      assertions++; if (ctrlEnable !== 1'b1) begin failures++; $display("[TB] FAIL ctrl_enable: got %b expected 1", ctrlEnable); end
      assertions++; if (ctrlStart !== 1'b1) begin failures++; $display("[TB] FAIL ctrl_start_pulse: got %b expected 1", ctrlStart); end
      @(posedge clk); #1;
      assertions++; if (ctrlStart !== 1'b0) begin failures++; $display("[TB] FAIL ctrl_start_width: got %b expected 0", ctrlStart); end
      wbRead(32'h100, rd);
      assertions++; if (rd !== 32'h1) begin failures++; $display("[TB] FAIL ctrl_read: got %h expected 00000001", rd); end
   endtask

   task automatic test_byte_sel();
      logic [31:0] rd;
      wbWrite(32'h304, 32'h0000_BEEF, 4'b0011);
      wbWrite(32'h304, 32'hDEAD_0000, 4'b1100);
      wbRead(32'h304, rd);
      assertions++; if (rd !== 32'hDEAD_BEEF) begin failures++; $display("[TB] FAIL tare1_bytes: got %h expected deadbeef", rd); end
      wbWrite(32'h328, 32'h1234_5678, 4'b0100);
      wbRead(32'h328, rd);
      assertions++; if (rd !== 32'h0034_0000) begin failures++; $display("[TB] FAIL scale2_byte2: got %h expected 00340000", rd); end
   endtask

   task automatic test_adc();
      logic [31:0] rd;
      wbWrite(32'h200, 32'hFFFF_FFF5, 4'hF);
      wbRead(32'h200, rd);
      assertions++; if (rd !== 32'h5) begin failures++; $display("[TB] FAIL adc_cfg: got %h expected 00000005", rd); end
      wbWrite(32'h204, 32'h1, 4'hF);
      assertions++; if (adcStart !== 1'b1) begin failures++; $display("[TB] FAIL adc_start_pulse: got %b expected 1", adcStart); end
      @(posedge clk); #1;
      assertions++; if (adcStart !== 1'b0) begin failures++; $display("[TB] FAIL adc_start_width: got %b expected 0", adcStart); end
      wbRead(32'h204, rd);
      assertions++; if (rd !== 32'h0) begin failures++; $display("[TB] FAIL adc_cmd_read: got %h expected 0", rd); end
      wbRead(32'h218, rd);
      assertions++; if (rd !== 32'h2222_0002) begin failures++; $display("[TB] FAIL adc_raw2: got %h expected 22220002", rd); end
      wbRead(32'h21C, rd);
      assertions++; if (rd !== 32'h3333_0003) begin failures++; $display("[TB] FAIL adc_raw3: got %h expected 33330003", rd); end
      wbRead(32'h108, rd);
      assertions++; if (rd !== 32'hA5) begin failures++; $display("[TB] FAIL status: got %h expected 000000a5", rd); end
      @(negedge clk); adcDone = 1'b1;
      @(negedge clk); adcDone = 1'b0;
      wbRead(32'h10C, rd);
      assertions++; if (rd !== 32'h4) begin failures++; $display("[TB] FAIL adc_done_irq: got %h expected 00000004", rd); end
   endtask

   task automatic test_unmapped();
      logic [31:0] rd;
      wbRead(32'h410, rd);
      assertions++; if (rd !== 32'h0) begin failures++; $display("[TB] FAIL evt_count_ch4: got %h expected 0", rd); end
      wbWrite(32'h310, 32'hFFFF_FFFF, 4'hF);
      wbRead(32'h310, rd);
      assertions++; if (rd !== 32'h0) begin failures++; $display("[TB] FAIL tare_ch4: got %h expected 0", rd); end
      wbWrite(32'h000, 32'h0, 4'hF);
      wbRead(32'h000, rd);
      assertions++; if (rd !== 32'h4849_4348) begin failures++; $display("[TB] FAIL id_ro: got %h expected 48494348", rd); end
      wbRead(32'h1000, rd);
      assertions++; if (rd !== 32'h0) begin failures++; $display("[TB] FAIL alias_1000: got %h expected 0", rd); end
      wbRead(32'h0FC, rd);
      assertions++; if (rd !== 32'h0) begin failures++; $display("[TB] FAIL hole_0fc: got %h expected 0", rd); end
   endtask

   task automatic test_saturate();
      logic [31:0] rd;
      wbWrite(32'h10C, 32'h7, 4'hF);
      wbRead(32'h10C, rd);
      assertions++; if (rd !== 32'h0) begin failures++; $display("[TB] FAIL irq_w1c_all: got %h expected 0", rd); end
      pulseEvt(2, 260);
      readCount(2, rd);
      assertions++; if (rd !== 32'hFF) begin failures++; $display("[TB] FAIL evt2_saturate: got %h expected 000000ff", rd); end
      wbRead(32'h10C, rd);
      assertions++; if (rd !== 32'h3) begin failures++; $display("[TB] FAIL irq_stat_ovf: got %h expected 00000003", rd); end
      wbWrite(32'h104, 32'h2, 4'hF);
      assertions++; if (irqEn !== 3'b010) begin failures++; $display("[TB] FAIL irq_en_out: got %b expected 010", irqEn); end
      @(posedge clk); #1;
      assertions++; if (irqO !== 1'b1) begin failures++; $display("[TB] FAIL irq_o_set: got %b expected 1", irqO); end
      wbWrite(32'h10C, 32'h2, 4'hF);
      assertions++; if (irqO !== 1'b1) begin failures++; $display("[TB] FAIL irq_o_latency: got %b expected 1", irqO); end
      @(posedge clk); #1;
      assertions++; if (irqO !== 1'b0) begin failures++; $display("[TB] FAIL irq_o_clear: got %b expected 0", irqO); end
      wbRead(32'h10C, rd);
      assertions++; if (rd !== 32'h1) begin failures++; $display("[TB] FAIL irq_stat_after_w1c: got %h expected 00000001", rd); end
   endtask

   task automatic test_collision();
      logic [31:0] rd;
      int lat;
      wbWrite(32'h440, 32'hF, 4'hF);
      pulseEvt(0, 3);
      readCount(0, rd);
      assertions++; if (rd !== 32'h3) begin failures++; $display("[TB] FAIL evt0_count: got %h expected 00000003", rd); end
      applyStimulus(1'b1, 32'h440, 32'h1, 4'hF, 4'b0001, rd, lat);
      readCount(0, rd);
      assertions++; if (rd !== 32'h0) begin failures++; $display("[TB] FAIL clr_beats_pulse: got %h expected 0", rd); end
      applyStimulus(1'b1, 32'h10C, 32'h1, 4'hF, 4'b0010, rd, lat);
      wbRead(32'h10C, rd);
      assertions++; if (rd !== 32'h1) begin failures++; $display("[TB] FAIL set_beats_w1c: got %h expected 00000001", rd); end
      readCount(1, rd);
      assertions++; if (rd !== 32'h1) begin failures++; $display("[TB] FAIL evt1_during_w1c: got %h expected 00000001", rd); end
      wbWrite(32'h10C, 32'h1, 4'hF);
      wbRead(32'h10C, rd);
      assertions++; if (rd !== 32'h0) begin failures++; $display("[TB] FAIL irq_evt_w1c: got %h expected 0", rd); end
   endtask

   task automatic test_enable_gate();
      logic [31:0] rd;
      wbWrite(32'h100, 32'h0, 4'hF);
      pulseEvt(3, 2);
      readCount(3, rd);
      assertions++; if (rd !== 32'h0) begin failures++; $display("[TB] FAIL disabled_count: got %h expected 0", rd); end
      wbWrite(32'h100, 32'h1, 4'hF);
      pulseEvt(3, 2);
      readCount(3, rd);
      assertions++; if (rd !== 32'h2) begin failures++; $display("[TB] FAIL enabled_count: got %h expected 00000002", rd); end
   endtask

   task automatic test_snapshot();
      logic [31:0] rd;
      logic [31:0] expFirst;
`ifdef HOME_INV_WB_SNAPSHOT_EN
      expFirst = 32'h5;
`else
      expFirst = 32'h7;
`endif
      wbWrite(32'h440, 32'hF, 4'hF);
      pulseEvt(1, 5);
      wbRead(32'h400, rd);
      assertions++; if (rd !== 32'h0) begin failures++; $display("[TB] FAIL snap_ch0_live: got %h expected 0", rd); end
      pulseEvt(1, 2);
      wbRead(32'h404, rd);
      assertions++; if (rd !== expFirst) begin failures++; $display("[TB] FAIL snap_ch1_first: got %h expected %h", rd, expFirst); end
      wbRead(32'h400, rd);
      wbRead(32'h404, rd);
      assertions++; if (rd !== 32'h7) begin failures++; $display("[TB] FAIL snap_ch1_second: got %h expected 00000007", rd); end
   endtask

   task automatic test_reset_midway();
      logic [31:0] rd;
      int ackCount = 0;
      @(negedge clk);
      stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h000; sel = 4'hF;
      @(posedge clk); #1;
      rstN = 1'b0;
      #1;
      if (ack) ackCount++;
      repeat (2) begin @(posedge clk); #1; if (ack) ackCount++; end
      @(negedge clk); stb = 1'b0; cyc = 1'b0;
      @(negedge clk); rstN = 1'b1;
      repeat (6) begin @(posedge clk); #1; if (ack) ackCount++; end
      assertions++; if (ackCount !== 0) begin failures++; $display("[TB] FAIL reset_abort_ack: got %0d acks expected 0", ackCount); end
      assertions++; if (ctrlEnable !== 1'b0) begin failures++; $display("[TB] FAIL reset_mid_enable: got %b expected 0", ctrlEnable); end
      wbRead(32'h000, rd);
      assertions++; if (rd !== 32'h4849_4348) begin failures++; $display("[TB] FAIL reset_fresh_read: got %h expected 48494348", rd); end
   endtask

   initial begin
      stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; datI = '0; adr = '0;
      coreStatus = 8'hA5; evtPulse = '0; adcDone = 1'b0;
      adcRaw = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0000_0000};
      test_reset();
      test_id_version();
      test_back_to_back();
      test_abort();
      test_ctrl();
      test_byte_sel();
      test_adc();
      test_unmapped();
      test_saturate();
      test_collision();
      test_enable_gate();
      test_snapshot();
      test_reset_midway();
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
